// File: rtl/sdram_pkg.sv
// Shared SDRAM-side definitions: write-packer state encoding, default burst
// geometry and fill byte, and a saturating counter helper.
package sdram_pkg;

  typedef enum logic {
    ST_PACK = 1'b0,
    ST_PAD  = 1'b1
  } wr_pack_state_t;

  localparam int         SDRAM_BURST_LEN_DEF = 256;
  localparam logic [7:0] SDRAM_PAD_BYTE_DEF  = 8'h00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sdram_wr_packer_if.sv
// Byte-stream handshake feeding the SDRAM write packer.
interface sdram_wr_packer_if;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       in_last;

  modport master (output in_vld, output in_data, output in_last, input  in_rdy);
  modport slave  (input  in_vld, input  in_data, input  in_last, output in_rdy);
endinterface

// File: rtl/sdram_wr_packer.sv
// Packs a byte stream into 16-bit SDRAM write-FIFO words, padding odd frames and,
// when SDRAM_WR_PACK_PAD_EN is defined, padding each frame to a whole burst.
module sdram_wr_packer
  import sdram_pkg::*;
#(
  parameter int         BURST_LEN = SDRAM_BURST_LEN_DEF,
  parameter logic [7:0] PAD_BYTE  = SDRAM_PAD_BYTE_DEF,
  parameter bit         LSB_FIRST = 1'b1
) (
  input  logic               w_clk,
  input  logic               rst,
  sdram_wr_packer_if.slave   stream,
  input  logic               fifo_full,
  output logic               wen,
  output logic [15:0]        din,
  output logic               frame_done,
  output logic [15:0]        frame_len
);

  localparam int BW = $clog2(BURST_LEN);

  wr_pack_state_t state_q, state_d;
  logic           half_q, half_d;
  logic [7:0]     hold_q, hold_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [15:0]    word_q, word_d;
  logic           wen_q, wen_d;
  logic [15:0]    din_q, din_d;
  logic           done_q, done_d;
  logic [15:0]    len_q, len_d;

  logic           rdy;
  logic           accept;
  logic [BW-1:0]  burst_inc;
  logic [15:0]    word_inc;

  function automatic logic [15:0] order(input logic [7:0] first, input logic [7:0] second);
    return LSB_FIRST ? {second, first} : {first, second};
  endfunction

  // The cycle carrying frame_done is held off so the next frame starts cleanly
  // after the counters have been cleared.
  assign rdy       = (state_q == ST_PACK) && !fifo_full && !done_q && !rst;
  assign accept    = stream.in_vld && rdy;
  assign burst_inc = burst_q + BW'(1);
  assign word_inc  = sat_inc16(word_q);

  assign stream.in_rdy = rdy;
  assign wen           = wen_q;
  assign din           = din_q;
  assign frame_done    = done_q;
  assign frame_len     = len_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    half_d  = half_q;
    hold_d  = hold_q;
    burst_d = burst_q;
    word_d  = word_q;
    wen_d   = 1'b0;
    din_d   = din_q;
    done_d  = 1'b0;
    len_d   = len_q;

    case (state_q)
      ST_PACK: begin
        if (accept) begin
          if (!half_q && !stream.in_last) begin
            hold_d = stream.in_data;
            half_d = 1'b1;
          end else begin
            wen_d   = 1'b1;
            din_d   = half_q ? order(hold_q, stream.in_data)
                             : order(stream.in_data, PAD_BYTE);
            half_d  = 1'b0;
            burst_d = burst_inc;
            word_d  = word_inc;
            if (stream.in_last) begin
`ifdef SDRAM_WR_PACK_PAD_EN
              if (burst_inc != '0) begin
                state_d = ST_PAD;
              end else begin
                done_d = 1'b1;
                len_d  = word_inc;
                word_d = '0;
              end
`else
              done_d = 1'b1;
              len_d  = word_inc;
              word_d = '0;
`endif
            end
          end
        end
      end
`ifdef SDRAM_WR_PACK_PAD_EN
      ST_PAD: begin
        if (!fifo_full) begin
          wen_d   = 1'b1;
          din_d   = {PAD_BYTE, PAD_BYTE};
          burst_d = burst_inc;
          word_d  = word_inc;
          if (burst_inc == '0) begin
            done_d  = 1'b1;
            len_d   = word_inc;
            word_d  = '0;
            state_d = ST_PACK;
          end
        end
      end
`endif
      default: state_d = ST_PACK;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before this edge.
  always_ff @(posedge w_clk) begin
    if (rst) begin
      state_q <= ST_PACK;
      half_q  <= 1'b0;
      hold_q  <= '0;
      burst_q <= '0;
      word_q  <= '0;
      wen_q   <= 1'b0;
      din_q   <= '0;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      hold_q  <= hold_d;
      burst_q <= burst_d;
      word_q  <= word_d;
      wen_q   <= wen_d;
      din_q   <= din_d;
      done_q  <= done_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_sdram_wr_packer.sv
// Scoreboard bench for sdram_wr_packer: two instances (fill bytes 00 and 5A)
// share one byte stream; expected words are queued as bytes are accepted.
module tb_sdram_wr_packer;

  localparam int BL = 4;

  typedef struct packed {
    logic [15:0] din;
    logic        done;
    logic [15:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic fifo_full;
  always #5 clk = ~clk;

  sdram_wr_packer_if if_a ();
  sdram_wr_packer_if if_b ();

  logic        wen_s  [2];
  logic [15:0] din_s  [2];
  logic        done_s [2];
  logic [15:0] len_s  [2];
  logic        rdy_s  [2];

  assign rdy_s[0] = if_a.in_rdy;
  assign rdy_s[1] = if_b.in_rdy;

  sdram_wr_packer #(.BURST_LEN(BL), .PAD_BYTE(8'h00), .LSB_FIRST(1'b1)) u_a (
    .w_clk(clk), .rst(rst), .stream(if_a), .fifo_full(fifo_full),
    .wen(wen_s[0]), .din(din_s[0]), .frame_done(done_s[0]), .frame_len(len_s[0])
  );

  sdram_wr_packer #(.BURST_LEN(BL), .PAD_BYTE(8'h5A), .LSB_FIRST(1'b1)) u_b (
    .w_clk(clk), .rst(rst), .stream(if_b), .fifo_full(fifo_full),
    .wen(wen_s[1]), .din(din_s[1]), .frame_done(done_s[1]), .frame_len(len_s[1])
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q [2][$];
  exp_t e;
  logic prev_done [2] = '{1'b0, 1'b0};

  // Reference model state
  logic       m_half;
  logic [7:0] m_held;
  int         m_bcnt;
  int         m_wcnt;

  task automatic model_reset();
    m_half = 1'b0;
    m_held = 8'h00;
    m_bcnt = 0;
    m_wcnt = 0;
  endtask

  task automatic push_all(input logic [15:0] w0, input logic [15:0] w1,
                          input logic done, input int len);
    q[0].push_back('{din: w0, done: done, len: 16'(len)});
    q[1].push_back('{din: w1, done: done, len: 16'(len)});
  endtask

  task automatic model_byte(input logic [7:0] d, input logic last);
    logic [15:0] w0, w1;
    if (!m_half && !last) begin
      m_held = d;
      m_half = 1'b1;
    end else begin
      if (m_half) begin
        w0 = {d, m_held};
        w1 = w0;
      end else begin
        w0 = {8'h00, d};
        w1 = {8'h5A, d};
      end
      m_half = 1'b0;
      m_bcnt = (m_bcnt + 1) % BL;
      m_wcnt++;
      if (!last) begin
        push_all(w0, w1, 1'b0, 0);
      end else begin
`ifdef SDRAM_WR_PACK_PAD_EN
        if (m_bcnt != 0) begin
          push_all(w0, w1, 1'b0, 0);
          while (m_bcnt != 0) begin
            m_bcnt = (m_bcnt + 1) % BL;
            m_wcnt++;
            push_all(16'h0000, 16'h5A5A, m_bcnt == 0, m_wcnt);
          end
        end else begin
          push_all(w0, w1, 1'b1, m_wcnt);
        end
`else
        push_all(w0, w1, 1'b1, m_wcnt);
`endif
        m_wcnt = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    if_a.in_vld = v; if_a.in_data = d; if_a.in_last = l;
    if_b.in_vld = v; if_b.in_data = d; if_b.in_last = l;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int cyc;
    @(negedge clk);
    drive(1'b1, d, last);
    cyc = 0;
    while (rdy_s[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rdy_s[0] !== 1'b1) begin
      $display("FAIL in_rdy_timeout: in_rdy=%b after %0d cycles, required 1", rdy_s[0], cyc);
      drive(1'b0, 8'h00, 1'b0);
    end else begin
      n_pass++;
      model_byte(d, last);
      @(posedge clk);
      #1 drive(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (q[0].size() != 0 || q[1].size() != 0)
      $display("FAIL drain_timeout: pending words a=%0d b=%0d, required 0",
               q[0].size(), q[1].size());
    else
      n_pass++;
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: every wen must match the head of its scoreboard queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        if (prev_done[k] && !fifo_full) begin
          n_checks++;
          if (rdy_s[k] === 1'b1) n_pass++;
          else $display("FAIL rdy_after_done[%0d]: in_rdy=%b, required 1", k, rdy_s[k]);
        end
        if (done_s[k] === 1'b1) begin
          n_checks++;
          if (rdy_s[k] === 1'b0) n_pass++;
          else $display("FAIL rdy_during_done[%0d]: in_rdy=%b, required 0", k, rdy_s[k]);
        end
        if (wen_s[k] === 1'b1) begin
          n_checks++;
          if (q[k].size() == 0) begin
            $display("FAIL unexpected_wen[%0d]: din=%h with no word expected", k, din_s[k]);
          end else begin
            e = q[k].pop_front();
            if (din_s[k] === e.din && done_s[k] === e.done &&
                (!e.done || len_s[k] === e.len))
              n_pass++;
            else
              $display("FAIL word[%0d]: din=%h done=%b len=%0d, required din=%h done=%b len=%0d",
                       k, din_s[k], done_s[k], len_s[k], e.din, e.done, e.len);
          end
        end else if (done_s[k] !== 1'b0) begin
          n_checks++;
          $display("FAIL done_without_wen[%0d]: frame_done=%b wen=%b", k, done_s[k], wen_s[k]);
        end
      end
      prev_done[k] = (done_s[k] === 1'b1) && !rst;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (rdy_s[k] === 1'b0 && wen_s[k] === 1'b0 && din_s[k] === 16'h0000 &&
          done_s[k] === 1'b0 && len_s[k] === 16'h0000)
        n_pass++;
      else
        $display("FAIL reset_values[%0d]: rdy=%b wen=%b din=%h done=%b len=%h, required 0 0 0000 0 0000",
                 k, rdy_s[k], wen_s[k], din_s[k], done_s[k], len_s[k]);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (rdy_s[k] === 1'b1) n_pass++;
      else $display("FAIL rdy_after_reset[%0d]: in_rdy=%b, required 1", k, rdy_s[k]);
    end
  endtask

  task automatic test_even_frame();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_drain();
  endtask

  task automatic test_odd_frame();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b1);
    wait_drain();
  endtask

  task automatic test_fifo_full_pad();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (wen_s[k] === 1'b0 && rdy_s[k] === 1'b0) n_pass++;
        else $display("FAIL stall_full[%0d]: wen=%b in_rdy=%b, required 0 0", k, wen_s[k], rdy_s[k]);
      end
    end
    fifo_full = 1'b0;
    wait_drain();
  endtask

  task automatic test_mid_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    wait_drain();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (wen_s[k] === 1'b0 && done_s[k] === 1'b0 && len_s[k] === 16'h0000) n_pass++;
        else $display("FAIL post_reset_quiet[%0d]: wen=%b done=%b len=%h, required 0 0 0000",
                      k, wen_s[k], done_s[k], len_s[k]);
      end
    end
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    wait_drain();
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), i == n - 1);
    end
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_even_frame();
    test_odd_frame();
    test_back_to_back();
    test_fifo_full_pad();
    test_mid_reset();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
